// File: rtl/lift_call_dispatcher.sv
// lift_call_dispatcher: latches floor-button presses and presents one floor
// request at a time to the three-floor lift controller. A call is retired
// once the lift has arrived and held its door open for DWELL_CYCLES cycles.
// A call that never arrives within TIMEOUT cycles raises a sticky fault.
module lift_call_dispatcher #(
  parameter int DWELL_CYCLES = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [1:0] lift_floor,
  input  logic       lift_moving,
  input  logic       lift_open,
  output logic [2:0] req,
  output logic [2:0] pending,
  output logic       busy,
  output logic       stuck
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DWELL    = 2'd2,
    CLOSE    = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] target;
  logic [7:0] cnt;
  logic [2:0] btn_q;

  logic [2:0] tgt_oh;
  logic [2:0] press;
  logic [2:0] press_ok;
  logic [2:0] pend_set;
  logic [1:0] sel;
  logic       arrive;

  // Nearest-first pick for the lift's current floor; floor 1 breaks the
  // 0/2 tie upwards, and the unused encoding 11 falls back to floor-0 order.
  function automatic logic [1:0] pick(input logic [2:0] p, input logic [1:0] f);
    logic [1:0] r;
    r = 2'd0;
    case (f)
      2'd1: begin
        if (p[1])      r = 2'd1;
        else if (p[2]) r = 2'd2;
        else           r = 2'd0;
      end
      2'd2: begin
        if (p[2])      r = 2'd2;
        else if (p[1]) r = 2'd1;
        else           r = 2'd0;
      end
      default: begin
        if (p[0])      r = 2'd0;
        else if (p[1]) r = 2'd1;
        else           r = 2'd2;
      end
    endcase
    return r;
  endfunction

  // Edge-detect buttons, decode target and outputs from registered state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
    tgt_oh   = 3'b001 << target;
    press    = btn & ~btn_q;
    // A target press during CLOSE is absorbed so the just-retired call stays cleared.
    press_ok = (state == CLOSE) ? (press & ~tgt_oh) : press;
    pend_set = pending | press_ok;
    sel      = pick(pending, lift_floor);
    arrive   = lift_open & ~lift_moving & (lift_floor == target);
    req      = ((state == DISPATCH) || (state == DWELL)) ? tgt_oh : 3'b000;
    busy     = (state != IDLE);
  end

  // Call latching, dispatch FSM, shared dwell/timeout counter and fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state   <= IDLE;
      target  <= 2'd0;
      cnt     <= 8'd0;
      pending <= 3'b000;
      stuck   <= 1'b0;
      // Loading the live level means a button held through reset is not a press.
      btn_q   <= btn;
    end else begin
      btn_q   <= btn;
      pending <= pend_set;
      case (state)
        IDLE: begin
          if (pending != 3'b000) begin
            target <= sel;
            cnt    <= 8'd0;
            state  <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (arrive) begin
            cnt   <= 8'd0;
            state <= DWELL;
          end else if (cnt == TMO_LAST) begin
            stuck   <= 1'b1;
            pending <= pend_set & ~tgt_oh;
            cnt     <= 8'd0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DWELL: begin
          if (!lift_open) begin
            cnt   <= 8'd0;
            state <= DISPATCH;
          end else if (cnt == DWELL_LAST) begin
            // Retire clear wins over a coincident press of the same floor.
            pending <= pend_set & ~tgt_oh;
            cnt     <= 8'd0;
            state   <= CLOSE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_call_dispatcher.sv
// Directed bench for lift_call_dispatcher. The lift controller's outputs are
// driven by hand to mimic arrivals, door openings and a lift that never opens.
module tb_lift_call_dispatcher;

  logic       clk;
  logic       reset;
  logic [2:0] btn;
  logic [1:0] lift_floor;
  logic       lift_moving;
  logic       lift_open;
  logic [2:0] req;
  logic [2:0] pending;
  logic       busy;
  logic       stuck;

  int checks;
  int failures;

  lift_call_dispatcher #(.DWELL_CYCLES(4), .TIMEOUT(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .lift_floor (lift_floor),
    .lift_moving(lift_moving),
    .lift_open  (lift_open),
    .req        (req),
    .pending    (pending),
    .busy       (busy),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    btn         = 3'b000;
    lift_floor  = 2'd0;
    lift_moving = 1'b0;
    lift_open   = 1'b0;

    // Reset state one edge after reset is sampled.
    step(1);
    check("rst_req", req, 3'b000);
    check("rst_pending", pending, 3'b000);
    check("rst_busy", {2'b00, busy}, 3'b000);
    check("rst_stuck", {2'b00, stuck}, 3'b000);
    step(1);
    reset = 1'b0;
    step(1);

    // 1. Single up call from floor 0 to floor 2.
    btn = 3'b100;
    step(1);
    check("s1_pend_set", pending, 3'b100);
    check("s1_not_busy_yet", {2'b00, busy}, 3'b000);
    btn = 3'b000;
    step(1);
    check("s1_req", req, 3'b100);
    check("s1_busy", {2'b00, busy}, 3'b001);
    lift_moving = 1'b1;
    step(2);
    lift_floor = 2'd1;
    step(1);
    lift_floor  = 2'd2;
    lift_moving = 1'b0;
    lift_open   = 1'b1;
    step(1);
    check("s1_dwell_req", req, 3'b100);
    step(3);
    check("s1_still_pending", pending, 3'b100);
    step(1);
    check("s1_retired", pending, 3'b000);
    check("s1_close_req", req, 3'b000);
    check("s1_close_busy", {2'b00, busy}, 3'b001);
    lift_open = 1'b0;
    step(1);
    check("s1_idle", {2'b00, busy}, 3'b000);

    // 2. Idle at floor 1, floors 0 and 2 pressed together: up wins.
    lift_floor = 2'd1;
    btn = 3'b101;
    step(1);
    check("s2_pend_101", pending, 3'b101);
    btn = 3'b000;
    step(1);
    check("s2_first_up", req, 3'b100);
    lift_floor = 2'd2;
    lift_open  = 1'b1;
    step(5);
    check("s2_pend_001", pending, 3'b001);
    lift_open = 1'b0;
    step(2);
    check("s2_second_down", req, 3'b001);
    lift_floor = 2'd0;
    lift_open  = 1'b1;
    step(5);
    check("s2_pend_000", pending, 3'b000);
    lift_open = 1'b0;
    step(1);

    // 3. Call at the current floor; a repeat press during CLOSE is absorbed.
    btn = 3'b001;
    step(1);
    btn = 3'b000;
    step(1);
    check("s3_req", req, 3'b001);
    lift_open = 1'b1;
    step(1);
    check("s3_dwell_req", req, 3'b001);
    step(3);
    check("s3_still_pending", pending, 3'b001);
    step(1);
    check("s3_retired", pending, 3'b000);
    lift_open = 1'b0;
    btn = 3'b001;
    step(1);
    check("s3_close_press_absorbed", pending, 3'b000);
    btn = 3'b000;
    check("s3_idle", {2'b00, busy}, 3'b000);
    step(1);

    // 4. Floors 2 and 0 pressed in the retire cycle while dwelling at floor 2.
    btn = 3'b100;
    step(1);
    btn = 3'b000;
    step(1);
    lift_floor = 2'd2;
    lift_open  = 1'b1;
    step(4);
    btn = 3'b101;
    step(1);
    check("s4_pend_after_retire", pending, 3'b001);
    check("s4_close_req", req, 3'b000);
    btn       = 3'b000;
    lift_open = 1'b0;
    step(2);
    check("s4_next_req", req, 3'b001);
    lift_floor = 2'd0;
    lift_open  = 1'b1;
    step(5);
    check("s4_done", pending, 3'b000);
    lift_open = 1'b0;
    step(1);

    // 5. Timeout: lift sits at floor 1 with door open but still moving.
    btn = 3'b010;
    step(1);
    btn         = 3'b000;
    lift_floor  = 2'd1;
    lift_moving = 1'b1;
    lift_open   = 1'b1;
    step(1);
    check("s5_req", req, 3'b010);
    step(31);
    check("s5_not_stuck_yet", {2'b00, stuck}, 3'b000);
    check("s5_still_dispatch", req, 3'b010);
    step(1);
    check("s5_stuck", {2'b00, stuck}, 3'b001);
    check("s5_pend_cleared", pending, 3'b000);
    check("s5_idle", {2'b00, busy}, 3'b000);
    lift_moving = 1'b0;
    lift_open   = 1'b0;
    lift_floor  = 2'd0;
    step(5);
    check("s5_stuck_sticky", {2'b00, stuck}, 3'b001);

    // 6. Reset during DISPATCH with floor 2 held high throughout.
    btn = 3'b100;
    step(2);
    check("s6_req", req, 3'b100);
    reset = 1'b1;
    step(1);
    check("s6_req_dropped", req, 3'b000);
    check("s6_pend_cleared", pending, 3'b000);
    check("s6_busy_cleared", {2'b00, busy}, 3'b000);
    check("s6_stuck_cleared", {2'b00, stuck}, 3'b000);
    reset = 1'b0;
    step(3);
    check("s6_held_not_press", pending, 3'b000);
    check("s6_stay_idle", {2'b00, busy}, 3'b000);
    btn = 3'b000;
    step(1);

    // 7. Unused floor code 11 selects with floor-0 order.
    lift_floor = 2'd3;
    btn = 3'b110;
    step(1);
    btn = 3'b000;
    step(1);
    check("s7_floor3_order", req, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lift_call_dispatcher.md
# lift_call_dispatcher

Call-side companion to the three-floor lift controller. It latches floor-button presses, presents one floor request at a time on the controller's `req` input, and watches the controller's `floor`/`moving`/`open` outputs. When the lift reaches the requested floor and has held the door open long enough, it retires that call. It sits between the button panel and the lift controller and is the only driver of `req`.

## Interface

**Parameters**
- `DWELL_CYCLES`, default 4: consecutive door-open cycles counted in DWELL before the call is retired (legal range 1 to 255).
- `TIMEOUT`, default 32: DISPATCH cycles allowed before arrival is declared failed (legal range 1 to 255).

**Ports**
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `btn`, input, 3: button levels. Bit i is floor i; a 0→1 transition is one press.
- `lift_floor`, input, 2: controller `floor` output. 00, 01 and 10 are valid.
- `lift_moving`, input, 1: controller `moving` output.
- `lift_open`, input, 1: controller `open` output.
- `req`, output, 3: one-hot floor request to the controller, or 000.
- `pending`, output, 3: latched unserved calls; also drives the button lamps.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `stuck`, output, 1: sticky fault flag, set on timeout. Only `reset` clears it.

## Operation

**Press detection**
- Register `btn_q` <= `btn` every cycle.
- `press[i]` = `btn[i] & ~btn_q[i]`.
- A press sets `pending[i]` at the next edge.
- During reset, `btn_q` loads `btn`. A button held through reset is therefore not a press.

**Target selection (IDLE only; target is latched until the call is retired)**
- Pick the first pending floor in priority order for the current `lift_floor`:
  - floor 0: 0, 1, 2
  - floor 1: 1, 2, 0 (tie between floors 0 and 2 goes up)
  - floor 2: 2, 1, 0
- `lift_floor` = 11 uses the floor-0 order.

**FSM states**
- **IDLE**
  - `req` = 000.
  - If `pending` ≠ 0: latch the target, clear `cnt`, go to DISPATCH.
- **DISPATCH**
  - `req` = onehot(target). `cnt` increments each cycle.
  - Arrival condition: `lift_open` & ~`lift_moving` & (`lift_floor` == target). On arrival, clear `cnt` and go to DWELL.
  - Else, if `cnt` == TIMEOUT−1: set `stuck`, clear `pending[target]`, go to IDLE.
- **DWELL**
  - `req` = onehot(target). Holding the request keeps the controller's door open.
  - While `lift_open` is high, `cnt` increments.
  - When `cnt` == DWELL_CYCLES−1 with `lift_open` high: clear `pending[target]`, go to CLOSE.
  - If `lift_open` falls: clear `cnt`, return to DISPATCH.
- **CLOSE**
  - `req` = 000 for exactly one cycle, so the door closes. Go to IDLE.

**Simultaneous events**
- A press of a non-target floor is latched in any state, including the cycle in which another call is retired.
- A press of the target floor is absorbed while in DWELL or CLOSE. If it coincides with the retire edge, the clear wins and `pending[target]` is 0 afterwards.
- A press of the target floor while in DISPATCH changes nothing; that call is already pending.

**Counters and widths**
- `cnt` is 8 bits and is shared between DISPATCH and DWELL.
- `cnt` never wraps: every exit path clears it.

## Timing

**Reset**
- Values one edge after `reset` is sampled high: `req` = 000, `pending` = 000, `busy` = 0, `stuck` = 0, state = IDLE, `cnt` = 0.
- Reset asserted mid-operation abandons the call, drops `req` at the next edge, and clears all pending calls.

**Latency**
- Press sampled at edge n sets `pending` after edge n.
- The FSM enters DISPATCH after edge n+1, so `req` is valid 2 cycles after the press.

**Door timing**
- `lift_open` is high for 1 arrival cycle plus DWELL_CYCLES cycles.
- `req` drops in CLOSE, so the controller's `open` falls in that same cycle.

**Timeout**
- `stuck` rises at the edge ending the TIMEOUT-th DISPATCH cycle.

**Output types**
- `req` and `busy` are decoded from the registered state and target.
- `pending` and `stuck` are registers.

## Test plan

All scenarios connect the DUT to the lift controller, with the controller starting at floor 0.

1. **Single up call.** Pulse `btn`=100 for one cycle.
   - `req`=100 two cycles later.
   - `lift_open` is high at floor 10 for 5 cycles (DWELL_CYCLES=4).
   - After that, `pending`=000, `req`=000, `busy`=0.
2. **Nearest-first ordering.** With the lift idle at floor 1, press floors 0 and 2 in the same cycle.
   - Floor 2 is served first, then floor 0.
   - `pending` goes 101 → 001 → 000.
3. **Current-floor call.** With the lift idle at floor 0, press `btn[0]`.
   - DISPATCH lasts 1 cycle.
   - Door opens without `moving`.
   - `pending[0]` clears after 4 DWELL cycles.
4. **Press during dwell.** While dwelling at floor 2, press floors 2 and 0 in the retire cycle.
   - `pending` becomes 001 (floor 2 absorbed).
   - Floor 0 is served next.
5. **Timeout.** Drive the lift inputs from the bench instead of the controller, with `lift_open` held at 0. Press floor 1.
   - `stuck`=1 after 32 DISPATCH cycles.
   - `pending[1]`=0, FSM returns to IDLE.
   - `stuck` stays 1 until `reset`.
6. **Reset mid-operation.** Assert `reset` during DISPATCH with `btn[2]` held high.
   - All outputs are 0 after the next edge.
   - No new call is registered after reset deasserts while `btn` stays high.
